vertical_sync_monitor: RTL

Receive-side checker for the vertical sync stream driven by the VGA timing generator. It samples vga_vsync on the system clock and locks onto the frame timing. From that timing it recovers the active window and the downscaled row address (0..95, each row repeated 5 lines). It flags pulse-width and frame-period violations. It is used in-system as a frame-lock indicator and on the bench as a self-checking scoreboard for the sync path.

---
 rtl/vertical_sync_monitor_if.sv | 31 +++
 rtl/vertical_sync_monitor.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/vertical_sync_monitor_if.sv
// Vertical sync monitor bus.
//   vga_vsync   : vsync under test (active-low pulse), driven by the generator side
//   frame_start : one-cycle strobe per detected vsync falling edge
//   active_v    : recovered active window
//   row_addr    : recovered downscaled row address
//   pulse_err   : one-cycle strobe, vsync low width violation
//   period_err  : one-cycle strobe, frame period violation
//   vsync_lock  : frame lock indicator
//   frame_count : completed error-free frames
interface vertical_sync_monitor_if;
  logic        vga_vsync;
  logic        frame_start;
  logic        active_v;
  logic [6:0]  row_addr;
  logic        pulse_err;
  logic        period_err;
  logic        vsync_lock;
  logic [15:0] frame_count;

  modport master (
    output vga_vsync,
    input  frame_start, active_v, row_addr, pulse_err, period_err,
           vsync_lock, frame_count
  );

  modport slave (
    input  vga_vsync,
    output frame_start, active_v, row_addr, pulse_err, period_err,
           vsync_lock, frame_count
  );
endinterface

// File: rtl/vertical_sync_monitor.sv
// Receive-side vertical sync checker. Locks onto the vsync frame timing,
// recovers the active window and downscaled row address, and flags pulse
// width and frame period violations.
//   clk   : system clock (same domain as the generator)
//   reset : asynchronous, active-high
//   bus   : vertical_sync_monitor_if slave (vga_vsync in, status out)
module vertical_sync_monitor #(
  parameter int unsigned VS_PULSE    = 3200,
  parameter int unsigned VS_BACK     = 46400,
  parameter int unsigned VS_ACTIVE   = 768000,
  parameter int unsigned VS_FRONT    = 16000,
  parameter int unsigned ROW_CYCLES  = 8000,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input logic                    clk,
  input logic                    reset,
  vertical_sync_monitor_if.slave bus
);

  localparam int unsigned FRAME = VS_PULSE + VS_BACK + VS_ACTIVE + VS_FRONT;
  localparam int unsigned FC_W  = $clog2(2 * FRAME + 1);
  localparam int unsigned SUB_W = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam int unsigned LK_W  = $clog2(LOCK_FRAMES + 1);

  localparam logic [FC_W-1:0]  PULSE_NOM = FC_W'(VS_PULSE);
  localparam logic [FC_W-1:0]  PULSE_MAX = FC_W'(2 * VS_PULSE + 1);
  localparam logic [FC_W-1:0]  ACT_START = FC_W'(VS_PULSE + VS_BACK);
  localparam logic [FC_W-1:0]  ACT_END   = FC_W'(VS_PULSE + VS_BACK + VS_ACTIVE);
  localparam logic [FC_W-1:0]  FRAME_NOM = FC_W'(FRAME);
  localparam logic [FC_W-1:0]  FRAME_MAX = FC_W'(2 * FRAME);
  localparam logic [SUB_W-1:0] ROW_LAST  = SUB_W'(ROW_CYCLES - 1);
  localparam logic [LK_W-1:0]  LOCK_MAX  = LK_W'(LOCK_FRAMES);

  typedef enum logic [2:0] {SEARCH, PULSE, BACK, ACTIVE, FRONT} state_t;

  state_t            state;
  logic              vs_d;
  logic [FC_W-1:0]   fc;
  logic [SUB_W-1:0]  sub_cnt;
  logic [LK_W-1:0]   lock_cnt;
  logic [LK_W-1:0]   lock_next;
  logic              frame_err;   // pulse error seen in the frame being measured
  logic              fe;
  logic              re;

  logic              frame_start;
  logic              active_v;
  logic [6:0]        row_addr;
  logic              pulse_err;
  logic              period_err;
  logic              vsync_lock;
  logic [15:0]       frame_count;

  always_comb begin
    fe = vs_d & ~bus.vga_vsync;
    re = ~vs_d & bus.vga_vsync;
    lock_next = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SEARCH;
      vs_d        <= 1'b0;
      fc          <= '0;
      sub_cnt     <= '0;
      lock_cnt    <= '0;
      frame_err   <= 1'b0;
      frame_start <= 1'b0;
      active_v    <= 1'b0;
      row_addr    <= '0;
      pulse_err   <= 1'b0;
      period_err  <= 1'b0;
      vsync_lock  <= 1'b0;
      frame_count <= '0;
    end else begin
      vs_d        <= bus.vga_vsync;
      frame_start <= 1'b0;
      pulse_err   <= 1'b0;
      period_err  <= 1'b0;
      if (state != SEARCH)
        fc <= fc + 1'b1;

      if (fe) begin
        // A falling edge always restarts measurement and wins over any
        // timeout compare falling on the same cycle.
        fc          <= FC_W'(1);
        frame_start <= 1'b1;
        frame_err   <= 1'b0;
        active_v    <= 1'b0;
        row_addr    <= '0;
        sub_cnt     <= '0;
        state       <= PULSE;
        if (state != SEARCH) begin
          if (fc != FRAME_NOM) begin
            period_err <= 1'b1;
            lock_cnt   <= '0;
            vsync_lock <= 1'b0;
          end else if (!frame_err) begin
            frame_count <= frame_count + 1'b1;
            lock_cnt    <= lock_next;
            vsync_lock  <= (lock_next == LOCK_MAX);
          end
        end
      end else begin
        case (state)
          PULSE: begin
            if (re) begin
              if (fc != PULSE_NOM) begin
                pulse_err  <= 1'b1;
                frame_err  <= 1'b1;
                lock_cnt   <= '0;
                vsync_lock <= 1'b0;
              end
              state <= BACK;
            end else if (fc == PULSE_MAX) begin
              pulse_err  <= 1'b1;
              lock_cnt   <= '0;
              vsync_lock <= 1'b0;
              state      <= SEARCH;
            end
          end
          BACK: begin
            if (fc == ACT_START) begin
              active_v <= 1'b1;
              row_addr <= '0;
              sub_cnt  <= '0;
              state    <= ACTIVE;
            end
          end
          ACTIVE: begin
            // Row address = (fc - first active) / ROW_CYCLES, tracked with a
            // wrapping sub-counter instead of a divider.
            if (fc == ACT_END) begin
              active_v <= 1'b0;
              row_addr <= '0;
              state    <= FRONT;
            end else if (sub_cnt == ROW_LAST) begin
              sub_cnt  <= '0;
              row_addr <= row_addr + 7'd1;
            end else begin
              sub_cnt <= sub_cnt + 1'b1;
            end
          end
          FRONT: begin
            if (fc == FRAME_MAX) begin
              period_err <= 1'b1;
              lock_cnt   <= '0;
              vsync_lock <= 1'b0;
              state      <= SEARCH;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.frame_start = frame_start;
    bus.active_v    = active_v;
    bus.row_addr    = row_addr;
    bus.pulse_err   = pulse_err;
    bus.period_err  = period_err;
    bus.vsync_lock  = vsync_lock;
    bus.frame_count = frame_count;
  end

endmodule
